// File: rtl/pipe_hz_pkg.sv
// pipe_hz_pkg: shared stage record type and forwarding constants for pipe_hazard_ctrl.
package pipe_hz_pkg;
    localparam int REC_AW = 8;
    localparam int FWD_DEPTH_MAX = 4;
    localparam int FWD_RF = 0;

    // rd is sized for the widest supported register file; narrower addresses are zero-extended.
    typedef struct packed {
        logic              valid;
        logic [REC_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_rec_t;

    function automatic logic wr_cap(input stage_rec_t r);
        return r.valid & r.regwrite & (r.rd != '0);
    endfunction
endpackage

// File: rtl/hz_fwd_sel.sv
// hz_fwd_sel: picks the nearest post-EX stage whose pending write matches one source register.
module hz_fwd_sel
    import pipe_hz_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int FSEL_W = $clog2(DEPTH + 1)
) (
    input  stage_rec_t        rec_i [DEPTH],
    input  logic [REC_AW-1:0] src_i,
    output logic [FSEL_W-1:0] sel_o
);
    // rec_i[j] is stage j+1; scanning from the far end lets the nearest match win.
    always_comb begin
        sel_o = FSEL_W'(FWD_RF);
        for (int k = DEPTH; k >= 1; k--)
            if (wr_cap(rec_i[k-1]) && rec_i[k-1].rd == src_i) sel_o = FSEL_W'(k);
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control with an internal in-flight destination shift register.
// Optional perf counters are built when PIPE_HZ_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_hz_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2,
    parameter int BR_STAGE  = 2,
    parameter int CNT_W     = 16,
    parameter int FSEL_W    = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              br_taken_i,
    output logic [FSEL_W-1:0] ex_fwd_a_o,
    output logic [FSEL_W-1:0] ex_fwd_b_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              bubble_o,
    output logic [BR_STAGE-1:0] kill_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);
    stage_rec_t        rec_q [FWD_DEPTH+1];
    stage_rec_t        rec_d [FWD_DEPTH+1];
    stage_rec_t        fwd_rec [FWD_DEPTH];
    logic [REG_AW-1:0] ex_rs_q, ex_rt_q;
    logic              load_use;

    assign load_use = id_valid_i & rec_q[0].valid & rec_q[0].memread & (rec_q[0].rd != '0) &
                      ((rec_q[0].rd == REC_AW'(id_rs_i)) |
                       (id_uses_rt_i & (rec_q[0].rd == REC_AW'(id_rt_i))));

    // A taken branch flushes everything younger, so it takes precedence over a load-use stall.
    assign pc_write_o   = br_taken_i | ~load_use;
    assign ifid_write_o = br_taken_i | ~load_use;
    assign ifid_flush_o = br_taken_i;
    assign bubble_o     = br_taken_i | load_use;
    assign kill_o       = {BR_STAGE{br_taken_i}};

    always_comb begin
        rec_d[0] = '{valid: id_valid_i & ~bubble_o, rd: REC_AW'(id_rd_i),
                     regwrite: id_regwrite_i, memread: id_memread_i};
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            rec_d[k] = rec_q[k-1];
            if (br_taken_i && k < BR_STAGE) rec_d[k].valid = 1'b0;
        end
        for (int k = 0; k < FWD_DEPTH; k++) fwd_rec[k] = rec_q[k+1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k <= FWD_DEPTH; k++) rec_q[k] <= '0;
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else begin
            rec_q   <= rec_d;
            ex_rs_q <= id_rs_i;
            ex_rt_q <= id_rt_i;
        end
    end

    hz_fwd_sel #(.DEPTH(FWD_DEPTH), .FSEL_W(FSEL_W)) u_fwd_a (
        .rec_i (fwd_rec),
        .src_i (REC_AW'(ex_rs_q)),
        .sel_o (ex_fwd_a_o)
    );

    hz_fwd_sel #(.DEPTH(FWD_DEPTH), .FSEL_W(FSEL_W)) u_fwd_b (
        .rec_i (fwd_rec),
        .src_i (REC_AW'(ex_rt_q)),
        .sel_o (ex_fwd_b_o)
    );

`ifdef PIPE_HZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = (load_use && !br_taken_i && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (br_taken_i && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif
endmodule
